// File: rtl/rgb2raw_bayer_mosaic_pkg.sv
// Shared types and helpers for the RGB to Bayer RAW re-mosaic path.
package rgb2raw_bayer_mosaic_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } colour_e;

  // Colour found at (Y[0],X[0]) = (0,0) for each BAYER_PHASE value.
  typedef enum logic [1:0] {
    PH_RGGB = 2'd0,
    PH_GRBG = 2'd1,
    PH_GBRG = 2'd2,
    PH_BGGR = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ARMED   = 2'd2,
    ST_ACTIVE  = 2'd3
  } frame_state_e;

  // Every phase is the RGGB map with its (y,x) parity flipped by the phase bits.
  function automatic colour_e bayer_colour(input logic [1:0] phase, input logic y0,
                                           input logic x0);
    logic [1:0] idx;
    idx = {y0, x0} ^ phase;
    case (idx)
      2'b00:   bayer_colour = COL_R;
      2'b11:   bayer_colour = COL_B;
      default: bayer_colour = COL_G;
    endcase
  endfunction

  // MSB replication keeps full scale at full scale (FF -> 3FF).
  function automatic logic [9:0] expand8to10(input logic [7:0] c);
    expand8to10 = {c, c[7:6]};
  endfunction

endpackage

// File: rtl/rgb2raw_bayer_mosaic_bayer_pos_counter.sv
// Pixel/line position counters with saturation and geometry-error detection.
module rgb2raw_bayer_mosaic_bayer_pos_counter
  import rgb2raw_bayer_mosaic_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_MAX = 11'd1279,
  parameter logic [CNT_W-1:0] V_MAX = 11'd1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_req_i,
  input  logic             vs_i,
  input  logic             hs_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             geom_err_o
);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             rd_req_q;
  logic             hs_q;

  // Next-state for the counters; VS low always forces Y to zero.
  always_comb begin
    x_d = '0;
    if (rd_req_i) begin
      x_d = (x_q == CNT_MAX) ? x_q : x_q + CNT_W'(1);
    end
    y_d = y_q;
    if (!vs_i) begin
      y_d = '0;
    end else if (rd_req_q && !rd_req_i) begin
      y_d = (y_q == CNT_MAX) ? y_q : y_q + CNT_W'(1);
    end
  end

  // Counter and edge-detect registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      rd_req_q <= 1'b0;
      hs_q     <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      rd_req_q <= rd_req_i;
      hs_q     <= hs_i;
    end
  end

  // A sample taken while VS is low belongs to line 0 of the new frame.
  assign x_o = x_q;
  assign y_o = vs_i ? y_q : '0;

  assign geom_err_o = rd_req_i && ((x_q > H_MAX) || (y_o > V_MAX) || (hs_q && !hs_i));

endmodule

// File: rtl/rgb2raw_bayer_mosaic.sv
// Re-mosaics an RGB stream into 10-bit Bayer RAW with regenerated LVAL/FVAL.
module rgb2raw_bayer_mosaic
  import rgb2raw_bayer_mosaic_pkg::*;
#(
  parameter logic [1:0]       BAYER_PHASE = 2'd1,
  parameter logic [CNT_W-1:0] H_MAX       = 11'd1279,
  parameter logic [CNT_W-1:0] V_MAX       = 11'd1023
) (
  input  logic             VGA_CLK,
  input  logic             RESET_N,
  input  logic [7:0]       iRed,
  input  logic [7:0]       iGreen,
  input  logic [7:0]       iBlue,
  input  logic             READ_Request,
  input  logic             VGA_VS,
  input  logic             VGA_HS,
  output logic [9:0]       oRAW,
  output logic             oLVAL,
  output logic             oFVAL,
  output logic [CNT_W-1:0] oX_Cont,
  output logic [CNT_W-1:0] oY_Cont,
  output logic             oERR
);

  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic             geom_err;

  frame_state_e state_q, state_d;
  logic         frame_start;
  logic         lval_tag, fval_tag;

  logic             s1_lval_q, s1_fval_q;
  logic [CNT_W-1:0] s1_x_q, s1_y_q;
  logic [7:0]       s1_r_q, s1_g_q, s1_b_q;

  colour_e          col;
  logic [7:0]       pix;
  logic [9:0]       raw_d, raw_q;
  logic             lval_q, fval_q, err_q, err_d;
  logic [CNT_W-1:0] xo_q, yo_q;

  rgb2raw_bayer_mosaic_bayer_pos_counter #(
    .H_MAX(H_MAX),
    .V_MAX(V_MAX)
  ) u_pos (
    .clk_i     (VGA_CLK),
    .rst_ni    (RESET_N),
    .rd_req_i  (READ_Request),
    .vs_i      (VGA_VS),
    .hs_i      (VGA_HS),
    .x_o       (x_cnt),
    .y_o       (y_cnt),
    .geom_err_o(geom_err)
  );

  // Frame FSM next-state; data is only passed once a VS has been seen.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      ST_IDLE:    state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (!VGA_VS) state_d = ST_ARMED;
      ST_ARMED: begin
        if (READ_Request && VGA_VS) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE:  if (!VGA_VS) state_d = ST_ARMED;
      default:    state_d = ST_IDLE;
    endcase
    lval_tag = READ_Request && ((state_q == ST_ARMED) || (state_q == ST_ACTIVE));
    fval_tag = (state_d == ST_ACTIVE);
    err_d    = geom_err ? 1'b1 : (frame_start ? 1'b0 : err_q);
  end

  // Frame state register.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Stage 0 capture: sample, position and frame tags travel together.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_lval_q <= 1'b0;
      s1_fval_q <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
    end else begin
      s1_lval_q <= lval_tag;
      s1_fval_q <= fval_tag;
      s1_x_q    <= x_cnt;
      s1_y_q    <= y_cnt;
      s1_r_q    <= iRed;
      s1_g_q    <= iGreen;
      s1_b_q    <= iBlue;
    end
  end

  // Stage 1 colour pick and bit expansion; RAW is forced to 0 outside LVAL.
  always_comb begin
    col = bayer_colour(BAYER_PHASE, s1_y_q[0], s1_x_q[0]);
    pix = s1_g_q;
    case (col)
      COL_R:   pix = s1_r_q;
      COL_B:   pix = s1_b_q;
      default: pix = s1_g_q;
    endcase
    raw_d = s1_lval_q ? expand8to10(pix) : 10'd0;
  end

  // Output registers and the sticky error flag.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      raw_q  <= '0;
      lval_q <= 1'b0;
      fval_q <= 1'b0;
      xo_q   <= '0;
      yo_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      raw_q  <= raw_d;
      lval_q <= s1_lval_q;
      fval_q <= s1_fval_q;
      xo_q   <= s1_x_q;
      yo_q   <= s1_y_q;
      err_q  <= err_d;
    end
  end

  assign oRAW    = raw_q;
  assign oLVAL   = lval_q;
  assign oFVAL   = fval_q;
  assign oX_Cont = xo_q;
  assign oY_Cont = yo_q;
  assign oERR    = err_q;

endmodule

// File: tb/tb_rgb2raw_bayer_mosaic.sv
// Bench for rgb2raw_bayer_mosaic: all four Bayer phases run side by side on one stimulus.
module tb_rgb2raw_bayer_mosaic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rr, vs, hs;
  logic [7:0] r_in, g_in, b_in;

  logic [9:0]  o_raw  [4];
  logic        o_lval [4];
  logic        o_fval [4];
  logic        o_err  [4];
  logic [10:0] o_x    [4];
  logic [10:0] o_y    [4];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    rgb2raw_bayer_mosaic #(.BAYER_PHASE(2'(gi))) u_dut (
      .VGA_CLK     (clk),
      .RESET_N     (rst_n),
      .iRed        (r_in),
      .iGreen      (g_in),
      .iBlue       (b_in),
      .READ_Request(rr),
      .VGA_VS      (vs),
      .VGA_HS      (hs),
      .oRAW        (o_raw[gi]),
      .oLVAL       (o_lval[gi]),
      .oFVAL       (o_fval[gi]),
      .oX_Cont     (o_x[gi]),
      .oY_Cont     (o_y[gi]),
      .oERR        (o_err[gi])
    );
  end

  typedef struct packed {
    logic       rr;
    logic       vs;
    logic       hs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } stim_t;

  typedef struct packed {
    logic            lval;
    logic            fval;
    logic [3:0][9:0] raw;
    logic [10:0]     x;
    logic [10:0]     y;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  // Reference state: "seen a VS since reset", "inside a valid frame", pixel/line index.
  bit m_first, m_sync, m_frame, m_prev_rr;
  int m_x, m_y;

  function automatic byte colour_at(input int p, input int y, input int x);
    string s;
    case (p)
      0:       s = "RGGB";
      1:       s = "GRBG";
      2:       s = "GBRG";
      default: s = "BGGR";
    endcase
    return s.getc(2 * (y % 2) + (x % 2));
  endfunction

  function automatic logic [9:0] ref_raw(input int p, input int y, input int x,
                                         input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    byte c;
    int  v;
    c = colour_at(p, y, x);
    v = (c == "R") ? int'(r) : (c == "G") ? int'(g) : int'(b);
    return 10'((v << 2) | (v >> 6));
  endfunction

  function automatic stim_t mk(input logic a_rr, input logic a_vs, input logic a_hs,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    stim_t s;
    s.rr = a_rr; s.vs = a_vs; s.hs = a_hs; s.r = r; s.g = g; s.b = b;
    return s;
  endfunction

  task automatic model_reset();
    m_first = 1; m_sync = 0; m_frame = 0; m_prev_rr = 0; m_x = 0; m_y = 0;
    exp_q.delete();
  endtask

  task automatic add_idle(input int n);
    repeat (n) stim_q.push_back(mk(0, 1, 1, 8'h00, 8'h00, 8'h00));
  endtask

  task automatic add_vs();
    repeat (2) stim_q.push_back(mk(0, 0, 1, 8'h00, 8'h00, 8'h00));
    add_idle(2);
  endtask

  // n active pixels then a short blanking gap containing an HS pulse.
  task automatic add_line(input int n, input bit rnd, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      if (rnd) stim_q.push_back(mk(1, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom)));
      else     stim_q.push_back(mk(1, 1, 1, r, g, b));
    end
    stim_q.push_back(mk(0, 1, 1, 8'h00, 8'h00, 8'h00));
    stim_q.push_back(mk(0, 1, 0, 8'h00, 8'h00, 8'h00));
    stim_q.push_back(mk(0, 1, 1, 8'h00, 8'h00, 8'h00));
  endtask

  // Drive one cycle, queue its expected output, return the expectation now due at the outputs.
  task automatic step(input stim_t s, output bit have, output exp_t e);
    exp_t n;
    int   xs, ys;
    rr = s.rr; vs = s.vs; hs = s.hs; r_in = s.r; g_in = s.g; b_in = s.b;
    xs = m_x;
    ys = s.vs ? m_y : 0;
    n.lval = s.rr && m_sync;
    n.fval = m_sync && s.vs && (m_frame || s.rr);
    for (int p = 0; p < 4; p++) n.raw[p] = n.lval ? ref_raw(p, ys, xs, s.r, s.g, s.b) : 10'd0;
    n.x = 11'(xs);
    n.y = 11'(ys);
    m_frame = n.fval;
    if (!m_first && !s.vs) m_sync = 1;
    m_first = 0;
    m_x = s.rr ? ((m_x < 2047) ? m_x + 1 : 2047) : 0;
    if (!s.vs) m_y = 0;
    else if (m_prev_rr && !s.rr) m_y = (m_y < 2047) ? m_y + 1 : 2047;
    m_prev_rr = s.rr;
    exp_q.push_back(n);
    @(posedge clk);
    @(negedge clk);
    have = 0;
    e    = '0;
    if (exp_q.size() >= 2) begin
      e    = exp_q.pop_front();
      have = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; rr = 0; vs = 1; hs = 1; r_in = 0; g_in = 0; b_in = 0;
    model_reset();
    #23;
    for (int p = 0; p < 4; p++) begin
      n_total++;
      if ({o_raw[p], o_lval[p], o_fval[p], o_x[p], o_y[p], o_err[p]} !== 35'd0) begin
        n_bad++;
        $display("FAIL reset ph%0d: raw=%h lval=%b fval=%b x=%0d y=%0d err=%b, want all 0",
                 p, o_raw[p], o_lval[p], o_fval[p], o_x[p], o_y[p], o_err[p]);
      end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_line();
    bit   have;
    exp_t e;
    add_idle(2);
    add_vs();
    add_line(4, 0, 8'hFF, 8'h80, 8'h00);
    foreach (stim_q[i]) begin
      step(stim_q[i], have, e);
      if (have) for (int p = 0; p < 4; p++) begin
        n_total++;
        if ({o_lval[p], o_fval[p], o_raw[p]} !== {e.lval, e.fval, e.raw[p]}) begin
          n_bad++;
          $display("FAIL single_line ph%0d: lval/fval/raw got %b/%b/%h want %b/%b/%h",
                   p, o_lval[p], o_fval[p], o_raw[p], e.lval, e.fval, e.raw[p]);
        end
        if (e.lval) begin
          n_total++;
          if ({o_x[p], o_y[p]} !== {e.x, e.y}) begin
            n_bad++;
            $display("FAIL single_line_pos ph%0d: x/y got %0d/%0d want %0d/%0d",
                     p, o_x[p], o_y[p], e.x, e.y);
          end
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_two_lines();
    bit   have;
    exp_t e;
    add_vs();
    add_line(4, 0, 8'd10, 8'd20, 8'd30);
    add_line(4, 0, 8'd10, 8'd20, 8'd30);
    foreach (stim_q[i]) begin
      step(stim_q[i], have, e);
      if (have) for (int p = 0; p < 4; p++) begin
        n_total++;
        if ({o_lval[p], o_fval[p], o_raw[p]} !== {e.lval, e.fval, e.raw[p]}) begin
          n_bad++;
          $display("FAIL two_lines ph%0d: lval/fval/raw got %b/%b/%h want %b/%b/%h",
                   p, o_lval[p], o_fval[p], o_raw[p], e.lval, e.fval, e.raw[p]);
        end
        if (e.lval) begin
          n_total++;
          if ({o_x[p], o_y[p]} !== {e.x, e.y}) begin
            n_bad++;
            $display("FAIL two_lines_pos ph%0d: x/y got %0d/%0d want %0d/%0d",
                     p, o_x[p], o_y[p], e.x, e.y);
          end
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_random_frames();
    bit   have;
    exp_t e;
    repeat (3) begin
      add_vs();
      repeat (3) add_line(int'($urandom_range(1, 8)), 1, 8'h00, 8'h00, 8'h00);
      add_idle(int'($urandom_range(0, 3)));
    end
    foreach (stim_q[i]) begin
      step(stim_q[i], have, e);
      if (have) for (int p = 0; p < 4; p++) begin
        n_total++;
        if ({o_lval[p], o_fval[p], o_raw[p]} !== {e.lval, e.fval, e.raw[p]}) begin
          n_bad++;
          $display("FAIL random ph%0d: lval/fval/raw got %b/%b/%h want %b/%b/%h",
                   p, o_lval[p], o_fval[p], o_raw[p], e.lval, e.fval, e.raw[p]);
        end
        if (e.lval) begin
          n_total++;
          if ({o_x[p], o_y[p]} !== {e.x, e.y}) begin
            n_bad++;
            $display("FAIL random_pos ph%0d: x/y got %0d/%0d want %0d/%0d",
                     p, o_x[p], o_y[p], e.x, e.y);
          end
        end
      end
    end
    stim_q.delete();
  endtask

  // Line longer than H_MAX+1 (and past 2047 so X saturation shows), then a fresh frame.
  task automatic test_overflow();
    bit   have, want;
    exp_t e;
    int   i_bad, i_start;
    add_vs();
    i_bad = stim_q.size() + 1280;
    add_line(2050, 1, 8'h00, 8'h00, 8'h00);
    add_vs();
    i_start = stim_q.size();
    add_line(4, 1, 8'h00, 8'h00, 8'h00);
    foreach (stim_q[i]) begin
      step(stim_q[i], have, e);
      if (have) for (int p = 0; p < 4; p++) begin
        n_total++;
        if ({o_lval[p], o_fval[p], o_raw[p]} !== {e.lval, e.fval, e.raw[p]}) begin
          n_bad++;
          $display("FAIL overflow ph%0d: lval/fval/raw got %b/%b/%h want %b/%b/%h",
                   p, o_lval[p], o_fval[p], o_raw[p], e.lval, e.fval, e.raw[p]);
        end
        if (e.lval) begin
          n_total++;
          if ({o_x[p], o_y[p]} !== {e.x, e.y}) begin
            n_bad++;
            $display("FAIL overflow_pos ph%0d: x/y got %0d/%0d want %0d/%0d",
                     p, o_x[p], o_y[p], e.x, e.y);
          end
        end
      end
      if (i == i_bad - 1 || i == i_bad || i == i_start - 1 || i == i_start) begin
        want = (i == i_bad) || (i == i_start - 1);
        for (int p = 0; p < 4; p++) begin
          n_total++;
          if (o_err[p] !== want) begin
            n_bad++;
            $display("FAIL overflow_err ph%0d step %0d: err got %b want %b", p, i, o_err[p], want);
          end
        end
      end
    end
    stim_q.delete();
  endtask

  // HS falling inside a line, then VS dropping while a line is still active.
  task automatic test_hs_vs_events();
    bit   have, want;
    exp_t e;
    int   i_hs, i_clr;
    i_hs = stim_q.size() + 2;
    stim_q.push_back(mk(1, 1, 1, 8'h11, 8'h22, 8'h33));
    stim_q.push_back(mk(1, 1, 1, 8'h44, 8'h55, 8'h66));
    stim_q.push_back(mk(1, 1, 0, 8'h77, 8'h88, 8'h99));
    stim_q.push_back(mk(1, 1, 1, 8'hAA, 8'hBB, 8'hCC));
    add_idle(3);
    for (int k = 0; k < 6; k++)
      stim_q.push_back(mk(1, (k < 3) ? 1'b1 : 1'b0, 1, 8'($urandom), 8'($urandom), 8'($urandom)));
    repeat (2) stim_q.push_back(mk(0, 0, 1, 8'h00, 8'h00, 8'h00));
    add_idle(2);
    i_clr = stim_q.size();
    add_line(4, 1, 8'h00, 8'h00, 8'h00);
    foreach (stim_q[i]) begin
      step(stim_q[i], have, e);
      if (have) for (int p = 0; p < 4; p++) begin
        n_total++;
        if ({o_lval[p], o_fval[p], o_raw[p]} !== {e.lval, e.fval, e.raw[p]}) begin
          n_bad++;
          $display("FAIL hs_vs ph%0d: lval/fval/raw got %b/%b/%h want %b/%b/%h",
                   p, o_lval[p], o_fval[p], o_raw[p], e.lval, e.fval, e.raw[p]);
        end
        if (e.lval) begin
          n_total++;
          if ({o_x[p], o_y[p]} !== {e.x, e.y}) begin
            n_bad++;
            $display("FAIL hs_vs_pos ph%0d: x/y got %0d/%0d want %0d/%0d",
                     p, o_x[p], o_y[p], e.x, e.y);
          end
        end
      end
      if (i == i_hs - 1 || i == i_hs || i == i_clr - 1 || i == i_clr) begin
        want = (i == i_hs) || (i == i_clr - 1);
        for (int p = 0; p < 4; p++) begin
          n_total++;
          if (o_err[p] !== want) begin
            n_bad++;
            $display("FAIL hs_err ph%0d step %0d: err got %b want %b", p, i, o_err[p], want);
          end
        end
      end
    end
    stim_q.delete();
  endtask

  // Reset mid-line: outputs clear at once, and data before the next VS is never valid.
  task automatic test_reset_midline();
    bit   have;
    exp_t e;
    for (int k = 0; k < 3; k++) step(mk(1, 1, 1, 8'hF0, 8'h0F, 8'h5A), have, e);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_total++;
      if ({o_raw[p], o_lval[p], o_fval[p], o_x[p], o_y[p], o_err[p]} !== 35'd0) begin
        n_bad++;
        $display("FAIL reset_midline ph%0d: raw=%h lval=%b fval=%b x=%0d y=%0d err=%b, want all 0",
                 p, o_raw[p], o_lval[p], o_fval[p], o_x[p], o_y[p], o_err[p]);
      end
    end
    rr = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    add_idle(1);
    add_line(4, 1, 8'h00, 8'h00, 8'h00);
    add_line(3, 1, 8'h00, 8'h00, 8'h00);
    add_vs();
    add_line(4, 1, 8'h00, 8'h00, 8'h00);
    foreach (stim_q[i]) begin
      step(stim_q[i], have, e);
      if (have) for (int p = 0; p < 4; p++) begin
        n_total++;
        if ({o_lval[p], o_fval[p], o_raw[p]} !== {e.lval, e.fval, e.raw[p]}) begin
          n_bad++;
          $display("FAIL after_reset ph%0d: lval/fval/raw got %b/%b/%h want %b/%b/%h",
                   p, o_lval[p], o_fval[p], o_raw[p], e.lval, e.fval, e.raw[p]);
        end
        if (e.lval) begin
          n_total++;
          if ({o_x[p], o_y[p]} !== {e.x, e.y}) begin
            n_bad++;
            $display("FAIL after_reset_pos ph%0d: x/y got %0d/%0d want %0d/%0d",
                     p, o_x[p], o_y[p], e.x, e.y);
          end
        end
      end
    end
    stim_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_line();
    test_two_lines();
    test_random_frames();
    test_overflow();
    test_hs_vs_events();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb2raw_bayer_mosaic.md
Name: rgb2raw_bayer_mosaic

Overview:
- Re-mosaics an RGB pixel stream into single-channel 10-bit Bayer RAW data under VGA-style timing.
- Produces the D8M raw stream that the demosaic path consumes, so the line-buffer/demosaic chain can be driven from a known RGB source (frame grabs, pattern generators) without the sensor.
- Tracks its own pixel/line counters and regenerates line/frame-valid strobes aligned with the output data.

Parameters:
- BAYER_PHASE, 2'd1, colour at (Y[0],X[0])=(0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
- H_MAX, 11'd1279, largest legal X index; more active pixels in a line is an error.
- V_MAX, 11'd1023, largest legal Y index; more active lines in a frame is an error.

Ports:
- VGA_CLK  in  1  pixel clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- iRed  in  8  red sample, qualified by READ_Request.
- iGreen  in  8  green sample.
- iBlue  in  8  blue sample.
- READ_Request  in  1  active-pixel enable (data valid).
- VGA_VS  in  1  vertical sync, active-low pulse.
- VGA_HS  in  1  horizontal sync, active-low pulse; used only for line-end checking.
- oRAW  out  10  Bayer RAW sample.
- oLVAL  out  1  line valid, aligned with oRAW.
- oFVAL  out  1  frame valid.
- oX_Cont  out  11  X index of the current oRAW sample.
- oY_Cont  out  11  Y index of the current oRAW sample.
- oERR  out  1  sticky geometry error.

Behaviour:
- Reset (async, RESET_N=0):
  - All outputs 0.
  - Internal X/Y counters 0.
  - Pipeline registers 0.
  - Frame state IDLE.
- Counters (stage 0):
  - X increments on every cycle with READ_Request=1.
  - X clears to 0 on the first cycle after READ_Request falls.
  - Y increments on each READ_Request falling edge, i.e. at end of an active line.
  - Y clears to 0 while VGA_VS=0.
  - Counters saturate at 2047 and never wrap.
- Frame FSM:
  - IDLE → WAIT_VS: on reset release.
  - WAIT_VS → ARMED: on VGA_VS low.
  - ARMED → ACTIVE: on the first READ_Request=1 after VGA_VS returns high.
  - ACTIVE → ARMED: on VGA_VS low.
  - oFVAL=1 only in ACTIVE, registered one cycle so it rises together with the first oLVAL.
  - Data arriving in WAIT_VS (mid-frame start after reset) is suppressed: oLVAL=0, oRAW=0.
- Colour select (stage 1):
  - Combine Y[0] and X[0] with BAYER_PHASE (XOR onto the RGGB map) to pick R, G or B.
  - Expand 8→10 bits by MSB replication: {c[7:0], c[7:6]}.
  - 8'hFF → 10'h3FF; 8'h00 → 10'h000; 8'h80 → 10'h202.
- Latency:
  - oRAW, oLVAL, oX_Cont and oY_Cont appear exactly 2 VGA_CLK cycles after the input sample.
  - When oLVAL=0, oRAW holds 0.
- Errors (oERR):
  - Set when X would exceed H_MAX, when Y would exceed V_MAX, or when VGA_HS falls while READ_Request=1.
  - Cleared only at the ARMED→ACTIVE transition or by reset.
  - When a set and a clear happen in the same cycle, set wins.
- Simultaneous events:
  - VGA_VS low with READ_Request=1: VS wins; Y clears, X keeps counting the line, and that data is emitted with oFVAL=0.
- Reset mid-frame: outputs drop to 0 immediately (async); the FSM restarts in WAIT_VS, so no partial frame is ever flagged valid.

Decomposition:
- Shared package (e.g. d8m_pkg) holds:
  - Bayer colour codes COL_R, COL_G, COL_B.
  - Phase encodings for BAYER_PHASE.
  - Frame-FSM state encoding.
  - Counter width constant CNT_W=11.
- One natural sub-module, bayer_pos_counter: the X/Y counters plus saturation and overflow detection, shareable with the read-side counter logic.
- Colour select, bit expansion and the FSM stay in the top module.

Test Plan:
- Reset then VS pulse, one line of 4 pixels RGB=(8'hFF,8'h80,8'h00), BAYER_PHASE=1 → oRAW = 202,3FF,202,3FF at +2 cycles, oX_Cont 0..3, oY_Cont 0, oLVAL 4 cycles, oFVAL rises with it.
- Two lines, BAYER_PHASE=0, R=10,G=20,B=30 → line0 oRAW=028,050,028,050; line1 oRAW=050,078,050,078.
- Line of H_MAX+2 pixels → oERR=1 from the overflow cycle; X saturates; oERR stays 1 until the next frame's first active pixel, then 0.
- Assert RESET_N=0 mid-line → all outputs 0 the same cycle; pixels before the next VS give oLVAL=0, oFVAL=0.
- VGA_HS low during READ_Request=1 → oERR=1; VGA_VS low concurrent with data → oY_Cont=0 and oFVAL=0 on those samples.
- Sweep BAYER_PHASE 0..3 over a 2x2 block with distinct R/G/B values → the colour at each (Y[0],X[0]) matches the table for every phase.
